// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4-row x 5-column active-low keypad, debounces
// the press and release of one key at a time, and emits one-cycle key
// events (newhex/hexcode, newop/opcode, eq) for the operand register stage.
module keypad_scanner #(
  parameter int SETTLE   = 16,
  parameter int DEBOUNCE = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row_n,
  output logic [4:0] col_n,
  output logic       newhex,
  output logic [3:0] hexcode,
  output logic       newop,
  output logic [1:0] opcode,
  output logic       eq
);

  localparam int CNT_MAX = (SETTLE > DEBOUNCE) ? SETTLE : DEBOUNCE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE - 1);

  localparam logic [1:0] S_SCAN = 2'd0;
  localparam logic [1:0] S_DEB  = 2'd1;
  localparam logic [1:0] S_FIRE = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [3:0]       r_meta;
  logic [3:0]       r_rs;
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_col;
  logic [1:0]       r_row;
  logic             r_newhex;
  logic             r_newop;
  logic             r_eq;
  logic [3:0]       r_hexcode;
  logic [1:0]       r_opcode;

  logic [2:0]       w_col_next;
  logic             w_any_low;
  logic             w_key_low;
  logic [1:0]       w_low_row;

  assign w_col_next = (r_col == 3'd4) ? 3'd0 : r_col + 3'd1;
  assign w_any_low  = ~&r_rs;
  assign w_key_low  = ~r_rs[r_row];

  assign col_n   = ~(5'b00001 << r_col);
  assign newhex  = r_newhex;
  assign newop   = r_newop;
  assign eq      = r_eq;
  assign hexcode = r_hexcode;
  assign opcode  = r_opcode;

  // Lowest-index low row wins when several keys share the scanned column.
  always_comb begin
    w_low_row = 2'd3;
    if (!r_rs[2]) w_low_row = 2'd2;
    if (!r_rs[1]) w_low_row = 2'd1;
    if (!r_rs[0]) w_low_row = 2'd0;
  end

  // Two-flop synchronizer for the asynchronous row inputs (idle = all high).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_meta <= 4'hF;
      r_rs   <= 4'hF;
    end else begin
      r_meta <= row_n;
      r_rs   <= r_meta;
    end
  end

  // Scan / debounce / fire / hold sequencer with registered key events.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_SCAN;
      r_cnt     <= '0;
      r_col     <= 3'd0;
      r_row     <= 2'd0;
      r_newhex  <= 1'b0;
      r_newop   <= 1'b0;
      r_eq      <= 1'b0;
      r_hexcode <= 4'h0;
      r_opcode  <= 2'b00;
    end else begin
      r_newhex <= 1'b0;
      r_newop  <= 1'b0;
      r_eq     <= 1'b0;
      case (r_state)
        S_SCAN: begin
          if (r_cnt == SETTLE_LAST) begin
            r_cnt <= '0;
            if (w_any_low) begin
              r_row   <= w_low_row;
              r_state <= S_DEB;
            end else begin
              r_col <= w_col_next;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DEB: begin
          if (!w_key_low) begin
            // A bounce: abandon this key and carry on from the next column.
            r_cnt   <= '0;
            r_col   <= w_col_next;
            r_state <= S_SCAN;
          end else if (r_cnt == DEB_LAST) begin
            // Events are registered so the pulse coincides with the FIRE cycle.
            r_cnt   <= '0;
            r_state <= S_FIRE;
            if (r_col != 3'd4) begin
              r_newhex  <= 1'b1;
              r_hexcode <= {r_row, r_col[1:0]};
            end else if (r_row == 2'd3) begin
              r_eq <= 1'b1;
            end else begin
              r_newop  <= 1'b1;
              r_opcode <= r_row;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_FIRE: begin
          r_cnt   <= '0;
          r_state <= S_HOLD;
        end
        default: begin
          // HOLD: wait for a clean release; any low sample restarts the count.
          if (w_key_low) begin
            r_cnt <= '0;
          end else if (r_cnt == DEB_LAST) begin
            r_cnt   <= '0;
            r_col   <= 3'd0;
            r_state <= S_SCAN;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: drives a modelled key matrix into keypad_scanner and
// scores every key event against a queue of expected events.
module tb_keypad_scanner;

  logic       clock;
  logic       reset;
  logic [3:0] row_n;
  logic [4:0] col_n;
  logic       newhex;
  logic [3:0] hexcode;
  logic       newop;
  logic [1:0] opcode;
  logic       eq;

  keypad_scanner #(.SETTLE(3), .DEBOUNCE(4)) dut (
    .clock  (clock),
    .reset  (reset),
    .row_n  (row_n),
    .col_n  (col_n),
    .newhex (newhex),
    .hexcode(hexcode),
    .newop  (newop),
    .opcode (opcode),
    .eq     (eq)
  );

  // key[r][c] = 1 means the switch at row r, column c is closed.
  logic [4:0] key [0:3];

  typedef struct {
    int kind;  // 0 hex, 1 operator, 2 equals
    int code;
  } exp_t;
  exp_t exp_q[$];

  int n_checks;
  int n_errors;
  int n_pulses;
  int prev_pulse;
  int n_hi;
  int obs;
  exp_t e;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Closed switch pulls its row low while its column is driven low.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++) row_n[r] = ~|(key[r] & ~col_n);
  end

  task automatic check(input string tag, input int got, input int want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  function automatic int col_code(input int c);
    logic [4:0] v;
    v = ~(5'b00001 << c);
    return int'(v);
  endfunction

  // Event monitor: score every pulse against the expectation queue.
  always @(negedge clock) begin
    if (reset) begin
      prev_pulse = 0;
    end else begin
      n_hi = 0;
      if (newhex) n_hi++;
      if (newop)  n_hi++;
      if (eq)     n_hi++;
      if (n_hi != 0) begin
        n_pulses++;
        check("pulse_onehot", n_hi, 1);
        check("pulse_gap", prev_pulse, 0);
        obs = newhex ? int'(hexcode) : (newop ? 16 + int'(opcode) : 32);
        if (exp_q.size() == 0) begin
          check("pulse_unexpected", obs, 255);
        end else begin
          e = exp_q.pop_front();
          check("pulse_code", obs, e.kind * 16 + e.code);
        end
      end
      prev_pulse = (n_hi != 0) ? 1 : 0;
    end
  end

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Bounded wait for the first cycle of column c (previous column differs).
  task automatic wait_col_start(input string tag, input int c);
    logic [4:0] prev;
    int n;
    n = 0;
    prev = col_n;
    @(negedge clock);
    while (!(col_n == 5'(col_code(c)) && prev != col_n) && n < 100) begin
      prev = col_n;
      @(negedge clock);
      n++;
    end
    check(tag, int'(col_n), col_code(c));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    n_checks = 0; n_errors = 0; n_pulses = 0; prev_pulse = 0;
    for (int r = 0; r < 4; r++) key[r] = 5'b0;
    reset = 1'b0;
    #2 reset = 1'b1;
    idle(3);
    check("rst_col_n",   int'(col_n),   col_code(0));
    check("rst_newhex",  int'(newhex),  0);
    check("rst_newop",   int'(newop),   0);
    check("rst_eq",      int'(eq),      0);
    check("rst_hexcode", int'(hexcode), 0);
    check("rst_opcode",  int'(opcode),  0);
    reset = 1'b0;

    // Idle scan: each column held 3 cycles, wrapping 4 -> 0.
    for (int k = 0; k < 16; k++) begin
      check($sformatf("scan_col_%0d", k), int'(col_n), col_code((k / 3) % 5));
      @(negedge clock);
    end

    // Row 2, column 1 -> hex 9, no repeat while held.
    key[2][1] = 1'b1;
    exp_q.push_back('{0, 9});
    wait_drain("hex9_event");
    idle(20);
    check("hold_col_held", int'(col_n), col_code(1));
    key[2][1] = 1'b0;
    idle(20);
    check("hex9_hexcode", int'(hexcode), 9);

    // Column 4: '-' then '='.
    key[1][4] = 1'b1;
    exp_q.push_back('{1, 1});
    wait_drain("op_sub_event");
    key[1][4] = 1'b0;
    idle(20);
    key[3][4] = 1'b1;
    exp_q.push_back('{2, 0});
    wait_drain("eq_event");
    key[3][4] = 1'b0;
    idle(20);
    check("eq_opcode_kept",  int'(opcode),  1);
    check("eq_hexcode_kept", int'(hexcode), 9);

    // Two-cycle bounce on column 0 row 0: rejected, scan resumes at column 1.
    wait_col_start("bounce_sync", 0);
    key[0][0] = 1'b1;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    key[0][0] = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("bounce_col1_a", int'(col_n), col_code(1));
    @(negedge clock);
    check("bounce_col1_b", int'(col_n), col_code(1));
    @(negedge clock);
    check("bounce_col1_c", int'(col_n), col_code(1));
    @(negedge clock);
    check("bounce_col2",   int'(col_n), col_code(2));
    idle(10);
    check("bounce_no_event", exp_q.size(), 0);

    // Rows 0 and 3 on column 2: row 0 wins; another key during HOLD ignored.
    key[0][2] = 1'b1;
    key[3][2] = 1'b1;
    exp_q.push_back('{0, 2});
    wait_drain("multi_hex2_event");
    check("multi_hexcode", int'(hexcode), 2);
    key[1][0] = 1'b1;
    idle(10);
    key[1][0] = 1'b0;
    idle(10);
    key[0][2] = 1'b0;
    key[3][2] = 1'b0;
    idle(20);
    check("multi_hexcode_kept", int'(hexcode), 2);

    // Reset while debouncing row 2, column 3.
    wait_col_start("rstdeb_sync", 3);
    key[2][3] = 1'b1;
    repeat (4) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("rstdeb_col_n",   int'(col_n),   col_code(0));
    check("rstdeb_newhex",  int'(newhex),  0);
    check("rstdeb_hexcode", int'(hexcode), 0);
    check("rstdeb_opcode",  int'(opcode),  0);
    key[2][3] = 1'b0;
    idle(3);
    reset = 1'b0;
    check("rstdeb_restart_col0", int'(col_n), col_code(0));
    idle(3);
    check("rstdeb_restart_col1", int'(col_n), col_code(1));
    idle(20);
    check("rstdeb_no_event", exp_q.size(), 0);
    check("pulse_total", n_pulses, 4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
